berger_memory_scrubber: RTL and testbench

//  Background read-side checker for the Berger-coded 16x12 memory. On start, walks every address

---
 rtl/berger_pkg.sv | 23 ++
 rtl/berger_zero_count.sv | 20 ++
 rtl/berger_memory_scrubber.sv | 143 ++++++++++++++
 tb/tb_berger_memory_scrubber.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/berger_pkg.sv
// Shared constants and state encoding for the Berger-coded memory scrubber.
// Codeword layout: {data, check}, check = number of zero bits in data.
package berger_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CHK_W  = 4;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_CNT_W  = 5;

    localparam int DEF_CW_W     = DEF_DATA_W + DEF_CHK_W;
    localparam int DEF_DATA_MSB = DEF_CW_W - 1;
    localparam int DEF_DATA_LSB = DEF_CHK_W;
    localparam int DEF_CHK_MSB  = DEF_CHK_W - 1;
    localparam int DEF_CHK_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } scrub_state_t;

endpackage

// File: rtl/berger_zero_count.sv
// Combinational count of zero bits in a data word; the same function the
// write-side encoder uses to generate Berger check bits.
module berger_zero_count #(
    parameter int DATA_W = 8,
    parameter int CHK_W  = 4
) (
    input  logic [DATA_W-1:0] data,
    output logic [CHK_W-1:0]  zeros
);

    always_comb begin
        zeros = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (!data[i]) begin
                zeros = zeros + CHK_W'(1);
            end
        end
    end

endmodule

// File: rtl/berger_memory_scrubber.sv
// Background scrubber: reads every codeword, recomputes the Berger check and
// reports mismatches. Yields the read port to host writes while issuing.
//
// state    | meaning
// ST_IDLE  | waiting for start; results of the last pass held
// ST_ISSUE | drive read of addr unless host is writing (stall)
// ST_CHECK | codeword for addr on mem_rd_data; compare and advance
// ST_DONE  | one-cycle done pulse, then back to idle
module berger_memory_scrubber
    import berger_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CHK_W  = DEF_CHK_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    host_wr_en,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W+CHK_W-1:0] mem_rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err_pulse,
    output logic [ADDR_W-1:0]       err_addr,
    output logic                    first_err_vld,
    output logic [ADDR_W-1:0]       first_err_addr,
    output logic [CNT_W-1:0]        err_count
);

    localparam int CW_W = DATA_W + CHK_W;

    scrub_state_t      state, state_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic              done_nx, err_pulse_nx, fev_nx;
    logic [ADDR_W-1:0] err_addr_nx, fea_nx;
    logic [CNT_W-1:0]  err_count_nx;
    logic [CHK_W-1:0]  zeros;
    logic              mismatch;
    logic              last_addr;

    berger_zero_count #(
        .DATA_W (DATA_W),
        .CHK_W  (CHK_W)
    ) u_zero_count (
        .data  (mem_rd_data[CW_W-1 -: DATA_W]),
        .zeros (zeros)
    );

    assign mismatch  = (zeros != mem_rd_data[CHK_W-1:0]);
    assign last_addr = (addr_q == {ADDR_W{1'b1}});
    assign mem_addr  = addr_q;

    always_comb begin
        state_nx     = state;
        addr_nx      = addr_q;
        done_nx      = 1'b0;
        err_pulse_nx = 1'b0;
        err_addr_nx  = err_addr;
        err_count_nx = err_count;
        fev_nx       = first_err_vld;
        fea_nx       = first_err_addr;
        mem_rd_en    = 1'b0;
        busy         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nx     = ST_ISSUE;
                    addr_nx      = '0;
                    err_count_nx = '0;
                    fev_nx       = 1'b0;
                    fea_nx       = '0;
                end
            end
            ST_ISSUE: begin
                busy      = 1'b1;
                mem_rd_en = !host_wr_en;
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (!host_wr_en) begin
                    state_nx = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy = 1'b1;
                if (abort) begin
                    state_nx = ST_IDLE;
                end else begin
                    if (mismatch) begin
                        err_pulse_nx = 1'b1;
                        err_addr_nx  = addr_q;
                        if (err_count != {CNT_W{1'b1}}) begin
                            err_count_nx = err_count + CNT_W'(1);
                        end
                        if (!first_err_vld) begin
                            fev_nx = 1'b1;
                            fea_nx = addr_q;
                        end
                    end
                    if (last_addr) begin
                        state_nx = ST_DONE;
                        done_nx  = 1'b1;
                    end else begin
                        addr_nx  = addr_q + ADDR_W'(1);
                        state_nx = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            done           <= 1'b0;
            err_pulse      <= 1'b0;
            err_addr       <= '0;
            err_count      <= '0;
            first_err_vld  <= 1'b0;
            first_err_addr <= '0;
        end else begin
            state          <= state_nx;
            addr_q         <= addr_nx;
            done           <= done_nx;
            err_pulse      <= err_pulse_nx;
            err_addr       <= err_addr_nx;
            err_count      <= err_count_nx;
            first_err_vld  <= fev_nx;
            first_err_addr <= fea_nx;
        end
    end

endmodule

// File: tb/tb_berger_memory_scrubber.sv
// Scoreboard bench: two scrubbers (5-bit and 2-bit error counters) share one
// memory model; expected reads, error pulses and done events are queued per pass.
module tb_berger_memory_scrubber;
    import berger_pkg::*;

    typedef struct {int addr; int cyc;} rd_t;
    typedef struct {int addr; int cyc; int cnt;} err_t;
    typedef struct {int cyc; int cnt; int fev; int fea;} done_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic host_wr_en = 1'b0;

    logic                a_rd_en, a_busy, a_done, a_err, a_fev;
    logic [3:0]          a_addr, a_err_addr, a_fea;
    logic [4:0]          a_cnt;
    logic [DEF_CW_W-1:0] a_rd_data = '0;
    logic                b_rd_en, b_busy, b_done, b_err, b_fev;
    logic [3:0]          b_addr, b_err_addr, b_fea;
    logic [1:0]          b_cnt;
    logic [DEF_CW_W-1:0] b_rd_data = '0;

    logic [DEF_CW_W-1:0] mem [16];
    int stall [16];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit sb_en = 1'b1;
    int last_cnt, last_fev, last_fea;

    rd_t   exp_rd[$];
    err_t  exp_err[$];
    done_t exp_done[$];
    rd_t   m_rd;
    err_t  m_err;
    done_t m_done;

    berger_memory_scrubber #(.CNT_W(5)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .host_wr_en(host_wr_en),
        .mem_rd_en(a_rd_en), .mem_addr(a_addr), .mem_rd_data(a_rd_data),
        .busy(a_busy), .done(a_done), .err_pulse(a_err), .err_addr(a_err_addr),
        .first_err_vld(a_fev), .first_err_addr(a_fea), .err_count(a_cnt));

    berger_memory_scrubber #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .host_wr_en(host_wr_en),
        .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rd_data(b_rd_data),
        .busy(b_busy), .done(b_done), .err_pulse(b_err), .err_addr(b_err_addr),
        .first_err_vld(b_fev), .first_err_addr(b_fea), .err_count(b_cnt));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_rd_en) a_rd_data <= mem[a_addr];
        if (b_rd_en) b_rd_data <= mem[b_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat3(input int c);
        return (c > 3) ? 3 : c;
    endfunction

    function automatic logic [DEF_CW_W-1:0] valid_cw(input logic [7:0] d);
        return {d, 4'(8 - $countones(d))};
    endfunction

    function automatic bit is_err(input logic [DEF_CW_W-1:0] cw);
        logic [7:0] d;
        logic [3:0] c;
        d = cw[DEF_DATA_MSB:DEF_DATA_LSB];
        c = cw[DEF_CHK_MSB:DEF_CHK_LSB];
        return (8 - $countones(d)) != int'(c);
    endfunction

    // Valid codeword then a 0->1 flip in the data field, check bits kept.
    function automatic logic [DEF_CW_W-1:0] corrupt_cw(input logic [7:0] d_in);
        logic [7:0] d;
        logic [3:0] c;
        int b;
        d = (d_in == 8'hFF) ? 8'h7E : d_in;
        c = 4'(8 - $countones(d));
        b = $urandom_range(0, 7);
        while (d[b]) b = (b + 1) % 8;
        d[b] = 1'b1;
        return {d, c};
    endfunction

    always @(negedge clk) begin
        if (rst && sb_en) begin
            if (a_rd_en) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", int'(a_addr), -1);
                else begin
                    m_rd = exp_rd.pop_front();
                    chk("rd_addr", int'(a_addr), m_rd.addr);
                    chk("rd_cycle", cyc, m_rd.cyc);
                    chk("rd_b_strobe", int'(b_rd_en), 1);
                    chk("rd_b_addr", int'(b_addr), m_rd.addr);
                end
            end else if (b_rd_en) chk("rd_b_unexpected", 1, 0);
            if (a_err) begin
                if (exp_err.size() == 0) chk("err_unexpected", int'(a_err_addr), -1);
                else begin
                    m_err = exp_err.pop_front();
                    chk("err_addr", int'(a_err_addr), m_err.addr);
                    chk("err_cycle", cyc, m_err.cyc);
                    chk("err_count", int'(a_cnt), m_err.cnt);
                    chk("err_b_pulse", int'(b_err), 1);
                    chk("err_b_count_sat", int'(b_cnt), sat3(m_err.cnt));
                end
            end else if (b_err) chk("err_b_unexpected", 1, 0);
            if (a_done) begin
                if (exp_done.size() == 0) chk("done_unexpected", cyc, -1);
                else begin
                    m_done = exp_done.pop_front();
                    chk("done_cycle", cyc, m_done.cyc);
                    chk("done_err_count", int'(a_cnt), m_done.cnt);
                    chk("done_first_vld", int'(a_fev), m_done.fev);
                    chk("done_first_addr", int'(a_fea), m_done.fea);
                    chk("done_busy_low", int'(a_busy), 0);
                    chk("done_b_pulse", int'(b_done), 1);
                    chk("done_b_count_sat", int'(b_cnt), sat3(m_done.cnt));
                end
            end else if (b_done) chk("done_b_unexpected", 1, 0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stalls();
        for (int a = 0; a < 16; a++) stall[a] = 0;
    endtask

    task automatic check_results(input string tag, input int cnt, input int fev, input int fea);
        chk({tag, "_busy"}, int'(a_busy), 0);
        chk({tag, "_count"}, int'(a_cnt), cnt);
        chk({tag, "_first_vld"}, int'(a_fev), fev);
        chk({tag, "_first_addr"}, int'(a_fea), fea);
        chk({tag, "_b_count"}, int'(b_cnt), sat3(cnt));
    endtask

    // Caller is #1 after an edge; start is driven in the current cycle.
    task automatic run_pass(input int abort_at);
        int t0, t, ecnt, fev, fea;
        rd_t r;
        err_t e;
        done_t d;
        t0 = cyc;
        start = 1'b1;
        abort = 1'b0;
        host_wr_en = 1'b0;
        t = t0 + 1;
        ecnt = 0;
        fev = 0;
        fea = 0;
        for (int a = 0; a < 16; a++) begin
            if (abort_at >= 0 && a > abort_at) break;
            t += stall[a];
            r.addr = a;
            r.cyc = t;
            exp_rd.push_back(r);
            if (is_err(mem[a]) && a != abort_at) begin
                ecnt++;
                if (fev == 0) begin
                    fev = 1;
                    fea = a;
                end
                e.addr = a;
                e.cyc = t + 2;
                e.cnt = ecnt;
                exp_err.push_back(e);
            end
            t += 2;
        end
        if (abort_at < 0) begin
            d.cyc = t;
            d.cnt = ecnt;
            d.fev = fev;
            d.fea = fea;
            exp_done.push_back(d);
        end
        next_cycle();
        chk("busy_after_start", int'(a_busy), 1);
        for (int a = 0; a < 16; a++) begin
            repeat (stall[a]) begin
                host_wr_en = 1'b1;
                start = 1'($urandom % 2);
                next_cycle();
            end
            host_wr_en = 1'b0;
            start = 1'($urandom % 2);
            next_cycle();
            host_wr_en = 1'($urandom % 2);
            if (a == abort_at) begin
                abort = 1'b1;
                next_cycle();
                abort = 1'b0;
                host_wr_en = 1'b0;
                start = 1'b0;
                check_results("abort", ecnt, fev, fea);
                chk("abort_rd_en", int'(a_rd_en), 0);
                break;
            end
            next_cycle();
        end
        start = 1'b0;
        host_wr_en = 1'b0;
        next_cycle();
        next_cycle();
        check_results("persist", ecnt, fev, fea);
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("err_queue_drained", exp_err.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        last_cnt = ecnt;
        last_fev = fev;
        last_fea = fea;
    endtask

    initial begin
        clear_stalls();
        for (int a = 0; a < 16; a++) mem[a] = valid_cw(8'(a * 29 + 3));
        mem[0] = valid_cw(8'h00);
        mem[1] = valid_cw(8'hFF);
        mem[2] = valid_cw(8'hA5);

        repeat (3) next_cycle();
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_done", int'(a_done), 0);
        chk("rst_err_pulse", int'(a_err), 0);
        chk("rst_rd_en", int'(a_rd_en), 0);
        chk("rst_mem_addr", int'(a_addr), 0);
        chk("rst_count", int'(a_cnt), 0);
        chk("rst_first_vld", int'(a_fev), 0);
        rst = 1'b1;
        next_cycle();

        // Clean memory: 16 reads, done 33 cycles after start, no errors.
        run_pass(-1);

        // Single 0->1 flip at addr 5.
        mem[5] = {8'hA7, 4'd4};
        run_pass(-1);

        // Errors at 2 and 14, then a clean pass clears results.
        mem[5] = valid_cw(8'h5C);
        mem[2] = corrupt_cw(8'hA5);
        mem[14] = corrupt_cw(8'h31);
        run_pass(-1);
        stall[7] = 3;
        run_pass(-1);
        clear_stalls();
        mem[2] = valid_cw(8'hA5);
        mem[14] = valid_cw(8'h31);
        run_pass(-1);

        // Abort in CHECK at addr 9 with an error there and one earlier.
        mem[3] = corrupt_cw(8'h12);
        mem[9] = corrupt_cw(8'h40);
        run_pass(9);

        // start and abort together in idle: nothing starts, results held.
        start = 1'b1;
        abort = 1'b1;
        next_cycle();
        start = 1'b0;
        abort = 1'b0;
        next_cycle();
        check_results("idle_abort", last_cnt, last_fev, last_fea);

        // All codewords corrupt: 2-bit counter saturates at 3.
        for (int a = 0; a < 16; a++) mem[a] = corrupt_cw(8'($urandom));
        run_pass(-1);

        for (int p = 0; p < 8; p++) begin
            for (int a = 0; a < 16; a++) begin
                mem[a] = ($urandom % 4 == 0) ? corrupt_cw(8'($urandom)) : valid_cw(8'($urandom));
                stall[a] = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            run_pass((p % 3 == 2) ? int'($urandom_range(0, 15)) : -1);
        end

        // Reset in the middle of a pass with errors already counted.
        clear_stalls();
        for (int a = 0; a < 16; a++) mem[a] = corrupt_cw(8'($urandom));
        sb_en = 1'b0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (12) next_cycle();
        chk("pre_reset_count_nonzero", int'(a_cnt != 0), 1);
        rst = 1'b0;
        next_cycle();
        chk("midrst_busy", int'(a_busy), 0);
        chk("midrst_rd_en", int'(a_rd_en), 0);
        chk("midrst_mem_addr", int'(a_addr), 0);
        chk("midrst_err_pulse", int'(a_err), 0);
        chk("midrst_err_addr", int'(a_err_addr), 0);
        chk("midrst_done", int'(a_done), 0);
        chk("midrst_count", int'(a_cnt), 0);
        chk("midrst_first_vld", int'(a_fev), 0);
        chk("midrst_first_addr", int'(a_fea), 0);
        chk("midrst_b_count", int'(b_cnt), 0);
        rst = 1'b1;
        next_cycle();
        sb_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
